// File: rtl/vram_arbiter.sv
`timescale 1ns / 1ps
// Time-slot arbiter sharing the single-port ZX display RAM between video scan-out and the CPU.
// Optional macro VRAM_CONTENTION_EN: CPU is held off for the whole active line.
module vram_arbiter #(
  parameter int unsigned CELL_CLKS = 16,
  localparam int unsigned PhaseW = $clog2(CELL_CLKS)
) (
  input  logic              clk,
  input  logic              reset,
  // Video side
  input  logic              fetch_en,
  input  logic [PhaseW-1:0] cell_phase,
  input  logic [12:0]       vid_pix_addr,
  input  logic [12:0]       vid_attr_addr,
  output logic [7:0]        vid_pix_data,
  output logic [7:0]        vid_attr_data,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [12:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  // RAM port
  output logic [12:0]       ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [PhaseW-1:0] PhPix     = PhaseW'(0);
  localparam logic [PhaseW-1:0] PhAttr    = PhaseW'(1);
  localparam logic [PhaseW-1:0] PhAttrCap = PhaseW'(2);
  localparam logic [PhaseW-1:0] PhLast    = PhaseW'(CELL_CLKS - 1);

  logic [0:0]  state_q, state_d;
  logic [12:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic [7:0]  pix_shadow_q, pix_shadow_d;
  logic [7:0]  attr_shadow_q, attr_shadow_d;
  logic [7:0]  vid_pix_q, vid_pix_d;
  logic [7:0]  vid_attr_q, vid_attr_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  logic slot_free;
  logic busy;
  logic vid_pix_slot;
  logic vid_attr_slot;
  logic cpu_issue;

`ifdef VRAM_CONTENTION_EN
  assign slot_free = ~fetch_en;
`else
  assign slot_free = ~fetch_en | (cell_phase >= PhAttrCap);
`endif

  assign busy          = (state_q == StBusy);
  assign vid_pix_slot  = fetch_en & (cell_phase == PhPix);
  assign vid_attr_slot = fetch_en & (cell_phase == PhAttr);
  assign cpu_issue     = ~busy & cpu_req & slot_free;

  // Port issue and CPU FSM. slot_free never overlaps a video slot, so the two
  // address sources cannot collide.
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;

    if (vid_pix_slot) begin
      ram_addr_d = vid_pix_addr;
    end else if (vid_attr_slot) begin
      ram_addr_d = vid_attr_addr;
    end

    case (state_q)
      StIdle: begin
        if (cpu_issue) begin
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        state_d = StIdle;
        // ram_we_q still marks the access type during the return cycle
        if (!ram_we_q) begin
          cpu_rdata_d = ram_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Video double buffer: capture into shadows, expose at the cell boundary.
  always_comb begin
    pix_shadow_d  = pix_shadow_q;
    attr_shadow_d = attr_shadow_q;
    vid_pix_d     = vid_pix_q;
    vid_attr_d    = vid_attr_q;

    if (fetch_en) begin
      if (cell_phase == PhAttr) begin
        pix_shadow_d = ram_rdata;
      end
      if (cell_phase == PhAttrCap) begin
        attr_shadow_d = ram_rdata;
      end
      if (cell_phase == PhLast) begin
        vid_pix_d  = pix_shadow_q;
        vid_attr_d = attr_shadow_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ram_addr_q    <= 13'h0000;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= 8'h00;
      pix_shadow_q  <= 8'h00;
      attr_shadow_q <= 8'h00;
      vid_pix_q     <= 8'h00;
      vid_attr_q    <= 8'h00;
      cpu_rdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      pix_shadow_q  <= pix_shadow_d;
      attr_shadow_q <= attr_shadow_d;
      vid_pix_q     <= vid_pix_d;
      vid_attr_q    <= vid_attr_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

  // Reset during the return cycle abandons the access: no ack, and the RAM must
  // not commit a pending write at the reset edge.
  assign cpu_ack       = busy & ~reset;
  assign ram_we        = ram_we_q & ~reset;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign cpu_rdata     = (cpu_ack && !ram_we_q) ? ram_rdata : cpu_rdata_q;
  assign cpu_wait      = cpu_req & ~cpu_ack & ~busy & ~slot_free;
  assign vid_pix_data  = vid_pix_q;
  assign vid_attr_data = vid_attr_q;

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns / 1ps
// Self-checking bench for vram_arbiter: behavioural RAM, reference memory and ack scoreboard.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [3:0]  cell_phase;
  logic [12:0] vid_pix_addr, vid_attr_addr;
  logic [7:0]  vid_pix_data, vid_attr_data;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  vram_arbiter #(.CELL_CLKS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .cell_phase    (cell_phase),
    .vid_pix_addr  (vid_pix_addr),
    .vid_attr_addr (vid_attr_addr),
    .vid_pix_data  (vid_pix_data),
    .vid_attr_data (vid_attr_data),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .cpu_rdata     (cpu_rdata),
    .cpu_wait      (cpu_wait),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro: data for the registered address is valid in the following cycle.
  logic [7:0] mem     [8192];
  logic [7:0] ref_mem [8192];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  typedef struct { logic we; logic [7:0] data; } sb_t;
  sb_t sb[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Ack monitor pops the scoreboard and checks read data.
  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected ack: got ack at %0t, expected none", $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (!e.we) check("cpu_rdata on ack", cpu_rdata, e.data);
        else       check("ack after write", cpu_ack, 1'b1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                            input bit drop, output int lat, output longint t_ack);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    sb.push_back('{we: we, data: (we ? 8'h00 : ref_mem[addr])});
    if (we) ref_mem[addr] = wd;
    lat = 0;
    forever begin
      @(negedge clk);
      if (cpu_ack === 1'b1) break;
      lat++;
      if (lat > 40) begin
        checks++;
        fails++;
        $display("FAIL cpu ack timeout: no ack after %0d cycles, expected ack", lat);
        break;
      end
      @(posedge clk); #1;
    end
    t_ack = $time;
    @(posedge clk); #1;
    if (drop) cpu_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " vid_pix"},   vid_pix_data,  8'h00);
    check({tag, " vid_attr"},  vid_attr_data, 8'h00);
    check({tag, " cpu_ack"},   cpu_ack,       1'b0);
    check({tag, " cpu_rdata"}, cpu_rdata,     8'h00);
    check({tag, " ram_addr"},  ram_addr,      13'h0000);
    check({tag, " ram_we"},    ram_we,        1'b0);
    check({tag, " ram_wdata"}, ram_wdata,     8'h00);
    check({tag, " cpu_wait"},  cpu_wait,      1'b0);
  endtask

  typedef struct { logic we; logic [12:0] addr; logic [7:0] wdata; int exp_lat; } cpu_vec_t;
  typedef struct {
    logic fe; logic req; logic chk_addr; logic [12:0] exp_addr; logic exp_ack; logic exp_wait;
  } ph_vec_t;

  cpu_vec_t cv[7];
  ph_vec_t  pv[6];

  initial begin
    int     lat;
    longint t0, t1, ta, tb, tc;
    logic   prev_req;

    cv[0] = '{we: 1'b1, addr: 13'h0100, wdata: 8'hA5, exp_lat: 1};
    cv[1] = '{we: 1'b0, addr: 13'h0100, wdata: 8'h00, exp_lat: 1};
    cv[2] = '{we: 1'b1, addr: 13'h1FFF, wdata: 8'h5A, exp_lat: 1};
    cv[3] = '{we: 1'b0, addr: 13'h1FFF, wdata: 8'h00, exp_lat: 1};
    cv[4] = '{we: 1'b1, addr: 13'h0000, wdata: 8'hC3, exp_lat: 1};
    cv[5] = '{we: 1'b0, addr: 13'h0000, wdata: 8'h00, exp_lat: 1};
    cv[6] = '{we: 1'b0, addr: 13'h0040, wdata: 8'h00, exp_lat: 1};

`ifdef VRAM_CONTENTION_EN
    pv[0] = '{fe: 1, req: 1, chk_addr: 0, exp_addr: 13'h0000, exp_ack: 0, exp_wait: 1};
    pv[1] = '{fe: 1, req: 1, chk_addr: 1, exp_addr: 13'h0042, exp_ack: 0, exp_wait: 1};
    pv[2] = '{fe: 1, req: 1, chk_addr: 1, exp_addr: 13'h1804, exp_ack: 0, exp_wait: 1};
    pv[3] = '{fe: 0, req: 1, chk_addr: 1, exp_addr: 13'h1804, exp_ack: 0, exp_wait: 0};
    pv[4] = '{fe: 0, req: 1, chk_addr: 1, exp_addr: 13'h0100, exp_ack: 1, exp_wait: 0};
    pv[5] = '{fe: 0, req: 0, chk_addr: 1, exp_addr: 13'h0100, exp_ack: 0, exp_wait: 0};
`else
    pv[0] = '{fe: 1, req: 1, chk_addr: 0, exp_addr: 13'h0000, exp_ack: 0, exp_wait: 1};
    pv[1] = '{fe: 1, req: 1, chk_addr: 1, exp_addr: 13'h0042, exp_ack: 0, exp_wait: 1};
    pv[2] = '{fe: 1, req: 1, chk_addr: 1, exp_addr: 13'h1804, exp_ack: 0, exp_wait: 0};
    pv[3] = '{fe: 1, req: 1, chk_addr: 1, exp_addr: 13'h0100, exp_ack: 1, exp_wait: 0};
    pv[4] = '{fe: 1, req: 0, chk_addr: 1, exp_addr: 13'h0100, exp_ack: 0, exp_wait: 0};
    pv[5] = '{fe: 1, req: 0, chk_addr: 1, exp_addr: 13'h0100, exp_ack: 0, exp_wait: 0};
`endif

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[13'h0040] = 8'h3C; ref_mem[13'h0040] = 8'h3C;
    mem[13'h1802] = 8'h47; ref_mem[13'h1802] = 8'h47;
    mem[13'h0041] = 8'h81; ref_mem[13'h0041] = 8'h81;
    mem[13'h1803] = 8'h38; ref_mem[13'h1803] = 8'h38;
    mem[13'h0042] = 8'h5A; ref_mem[13'h0042] = 8'h5A;
    mem[13'h1804] = 8'h07; ref_mem[13'h1804] = 8'h07;
    mem[13'h0200] = 8'h11; ref_mem[13'h0200] = 8'h11;

    reset = 1'b1; fetch_en = 1'b0; cell_phase = 4'd0;
    vid_pix_addr = 13'h0000; vid_attr_addr = 13'h1800;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000; cpu_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // CPU-only accesses with the video idle
    for (int i = 0; i < 7; i++) begin
      if (i == 0) t0 = $time;
      cpu_access(cv[i].we, cv[i].addr, cv[i].wdata, 1'b1, lat, t1);
      check("idle access latency", lat, cv[i].exp_lat);
      if (i == 1) check("idle write+read cycles", 32'((t1 - t0) / 10 + 1), 4);
    end

    // Back-to-back reads with cpu_req held
    cpu_access(1'b0, 13'h0100, 8'h00, 1'b0, lat, ta);
    cpu_access(1'b0, 13'h0040, 8'h00, 1'b0, lat, tb);
    cpu_access(1'b0, 13'h1802, 8'h00, 1'b1, lat, tc);
    check("b2b ack spacing 1", 32'(tb - ta), 20);
    check("b2b ack spacing 2", 32'(tc - tb), 20);
    @(negedge clk);
    check("cpu_rdata held", cpu_rdata, 8'h47);
    @(posedge clk); #1;

    // Scan-out: cell k fetches, cell k+1 shows its bytes
    fetch_en = 1'b1; vid_pix_addr = 13'h0040; vid_attr_addr = 13'h1802;
    for (int ph = 0; ph < 16; ph++) begin
      cell_phase = 4'(ph);
      @(negedge clk);
      check("pre-swap vid_pix", vid_pix_data, 8'h00);
      if (ph == 1) begin
        check("pix slot ram_addr", ram_addr, 13'h0040);
        check("video slot ram_we", ram_we, 1'b0);
      end
      if (ph == 2) check("attr slot ram_addr", ram_addr, 13'h1802);
      @(posedge clk); #1;
    end
    vid_pix_addr = 13'h0041; vid_attr_addr = 13'h1803;
    for (int ph = 0; ph < 16; ph++) begin
      cell_phase = 4'(ph);
      @(negedge clk);
      check("cell k+1 vid_pix", vid_pix_data, 8'h3C);
      check("cell k+1 vid_attr", vid_attr_data, 8'h47);
      @(posedge clk); #1;
    end

    // CPU read colliding with the video slots
    vid_pix_addr = 13'h0042; vid_attr_addr = 13'h1804;
    cpu_we = 1'b0; cpu_addr = 13'h0100; cpu_wdata = 8'h00;
    prev_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cell_phase = 4'(i);
      fetch_en   = pv[i].fe;
      cpu_req    = pv[i].req;
      if (pv[i].req && !prev_req) sb.push_back('{we: 1'b0, data: ref_mem[13'h0100]});
      prev_req = pv[i].req;
      @(negedge clk);
      check("slot cpu_ack", cpu_ack, pv[i].exp_ack);
      check("slot cpu_wait", cpu_wait, pv[i].exp_wait);
      if (pv[i].chk_addr) check("slot ram_addr", ram_addr, pv[i].exp_addr);
      if (i == 0) check("cell k+2 vid_pix", vid_pix_data, 8'h81);
      @(posedge clk); #1;
    end
    fetch_en = 1'b1;
    for (int ph = 6; ph < 16; ph++) begin
      cell_phase = 4'(ph);
      @(posedge clk); #1;
    end
    cell_phase = 4'd0;
    @(negedge clk);
    check("after collision vid_pix", vid_pix_data, 8'h5A);
    check("after collision vid_attr", vid_attr_data, 8'h07);
    @(posedge clk); #1;
    fetch_en = 1'b0;

    // Reset during a write's return cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h99;
    @(negedge clk);
    check("rst issue cycle ack", cpu_ack, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("rst busy ack", cpu_ack, 1'b0);
    check("rst busy ram_we", ram_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post-reset");
    @(posedge clk); #1;
    cpu_access(1'b0, 13'h0200, 8'h00, 1'b1, lat, t1);
    check("post-reset read latency", lat, 1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
